// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the regfile_param register file.
package regfile_pkg;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 5;
   // Widest data word the parity helper covers; narrower words are zero-extended.
   localparam int unsigned MaxDataW = 64;

   typedef enum logic {
      StSweep,
      StIdle
   } clr_state_e;

   // Even-parity bit: stored alongside data so the total number of ones is even.
   function automatic logic calc_parity(input logic [MaxDataW-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep engine: zeroes one entry per cycle after reset and on clr_req_i.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req_i,
   output logic              busy_o,
   output logic              sweep_we_o,
   output logic [ADDR_W-1:0] sweep_addr_o
);

   localparam logic [ADDR_W-1:0] LastPtr = '1;

   clr_state_e        state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              busy_q;

   // Sweep/idle sequencing with registered busy; clr_req during a sweep is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StSweep;
         ptr_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            StSweep: begin
               if (ptr_q == LastPtr) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  ptr_q   <= '0;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            StIdle: begin
               if (clr_req_i) begin
                  state_q <= StSweep;
                  busy_q  <= 1'b1;
                  ptr_q   <= '0;
               end
            end
            default: begin
               state_q <= StSweep;
               busy_q  <= 1'b1;
               ptr_q   <= '0;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign sweep_we_o   = busy_q;
   assign sweep_addr_o = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// 2-read/1-write register file with registered reads, write bypass and clear sweep.
// Optional stored even parity per entry when REGFILE_PARITY_EN is defined.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned ADDR_W   = DefAddrW,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1_i,
   input  logic [ADDR_W-1:0] rd_addr2_i,
   output logic [DATA_W-1:0] rd_data1_o,
   output logic [DATA_W-1:0] rd_data2_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_accept_o,
   input  logic              clr_req_i,
   output logic              busy_o
`ifdef REGFILE_PARITY_EN
   ,
   output logic              rd_perr1_o,
   output logic              rd_perr2_o
`endif
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_discard, zero1, zero2, byp1, byp2;
   logic [DATA_W-1:0] rd_data1_d, rd_data2_d;
   logic [DATA_W-1:0] rd_data1_q, rd_data2_q;

   regfile_clr_fsm #(
      .ADDR_W(ADDR_W)
   ) u_clr_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_req_i   (clr_req_i),
      .busy_o      (busy_o),
      .sweep_we_o  (sweep_we),
      .sweep_addr_o(sweep_addr)
   );

   assign wr_accept_o = wr_en_i & ~busy_o;
   assign wr_discard  = (ZERO_REG != 0) && (wr_addr_i == '0);
   assign zero1       = (ZERO_REG != 0) && (rd_addr1_i == '0);
   assign zero2       = (ZERO_REG != 0) && (rd_addr2_i == '0);
   assign byp1        = wr_accept_o && (wr_addr_i == rd_addr1_i);
   assign byp2        = wr_accept_o && (wr_addr_i == rd_addr2_i);

   // Array update: sweep clears take priority; user writes only land when accepted.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem_q[sweep_addr] <= '0;
      end else if (wr_accept_o && !wr_discard) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read-port next value: zero during sweep or for hardwired r0, else bypass or array.
   always_comb begin
      rd_data1_d = '0;
      rd_data2_d = '0;
      if (!busy_o) begin
         if (zero1)     rd_data1_d = '0;
         else if (byp1) rd_data1_d = wr_data_i;
         else           rd_data1_d = mem_q[rd_addr1_i];
         if (zero2)     rd_data2_d = '0;
         else if (byp2) rd_data2_d = wr_data_i;
         else           rd_data2_d = mem_q[rd_addr2_i];
      end
   end

   // Registered read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data1_q <= '0;
         rd_data2_q <= '0;
      end else begin
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
      end
   end

   assign rd_data1_o = rd_data1_q;
   assign rd_data2_o = rd_data2_q;

`ifdef REGFILE_PARITY_EN
   logic par_q [Depth];
   logic perr1_d, perr2_d, perr1_q, perr2_q;

   // Parity storage mirrors the data array; sweep stores parity 0 to match zero data.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         par_q[sweep_addr] <= 1'b0;
      end else if (wr_accept_o && !wr_discard) begin
         par_q[wr_addr_i] <= calc_parity(MaxDataW'(wr_data_i));
      end
   end

   // Parity check only applies to reads served from the array.
   always_comb begin
      perr1_d = !busy_o && !zero1 && !byp1 &&
                (calc_parity(MaxDataW'(mem_q[rd_addr1_i])) != par_q[rd_addr1_i]);
      perr2_d = !busy_o && !zero2 && !byp2 &&
                (calc_parity(MaxDataW'(mem_q[rd_addr2_i])) != par_q[rd_addr2_i]);
   end

   // Parity error flags registered alongside read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr1_q <= 1'b0;
         perr2_q <= 1'b0;
      end else begin
         perr1_q <= perr1_d;
         perr2_q <= perr2_d;
      end
   end

   assign rd_perr1_o = perr1_q;
   assign rd_perr2_o = perr2_q;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param against an array-based reference model.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rd_addr1, rd_addr2, wr_addr;
   logic [31:0] rd_data1, rd_data2, wr_data;
   logic        wr_en, wr_accept, clr_req, busy;
`ifdef REGFILE_PARITY_EN
   logic        rd_perr1, rd_perr2;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mem_m [32];
   bit          m_busy;
   int          sw_idx;
   logic [31:0] exp1, exp2;

   always #5 clk = ~clk;

   regfile_param dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr1_i (rd_addr1),
      .rd_addr2_i (rd_addr2),
      .rd_data1_o (rd_data1),
      .rd_data2_o (rd_data2),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .wr_accept_o(wr_accept),
      .clr_req_i  (clr_req),
      .busy_o     (busy)
`ifdef REGFILE_PARITY_EN
      ,
      .rd_perr1_o (rd_perr1),
      .rd_perr2_o (rd_perr2)
`endif
   );

   function automatic logic [31:0] model_read(input logic [4:0] a, input bit acc);
      if (a == 5'd0) return 32'h0;
      if (acc && wr_addr == a) return wr_data;
      return mem_m[a];
   endfunction

   task automatic model_reset();
      m_busy = 1'b1;
      sw_idx = 0;
      exp1   = 32'h0;
      exp2   = 32'h0;
   endtask

   // Advance the model by one clock using the currently driven inputs, then the DUT.
   task automatic tick();
      bit acc;
      acc = wr_en && !m_busy;
      if (m_busy) begin
         exp1 = 32'h0;
         exp2 = 32'h0;
         mem_m[sw_idx] = 32'h0;
         sw_idx++;
         if (sw_idx == 32) m_busy = 1'b0;
      end else begin
         exp1 = model_read(rd_addr1, acc);
         exp2 = model_read(rd_addr2, acc);
         if (acc && wr_addr != 5'd0) mem_m[wr_addr] = wr_data;
         if (clr_req) begin
            m_busy = 1'b1;
            sw_idx = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Count cycles with busy high, bounded; no comparison here.
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) n++;
         tick();
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
      rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
      #12;
      checks++;
      if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_state rd1=%h rd2=%h busy=%b required 0/0/1", rd_data1, rd_data2,
                  busy);
      end
      rst_n = 1'b1;
      model_reset();
      count_busy(n);
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL reset_busy_len got %0d required 32", n);
      end
   endtask

   task automatic test_read_all();
      for (int a = 0; a < 32; a++) begin
         rd_addr1 = 5'(a);
         rd_addr2 = 5'(31 - a);
         tick();
         checks++;
         if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL read_all a=%0d rd1=%h rd2=%h required 0", a, rd_data1, rd_data2);
         end
      end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (wr_accept !== 1'b1) begin
         errors++;
         $display("FAIL wr_accept_idle got %b required 1", wr_accept);
      end
      tick();
      wr_en = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
      tick();
      checks++;
      if (rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_read r5 rd1=%h rd2=%h required deadbeef", rd_data1, rd_data2);
      end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; rd_addr1 = 5'd7; rd_addr2 = 5'd5;
      tick();
      wr_en = 1'b0;
      checks++;
      if (rd_data1 !== 32'h12345678 || rd_data2 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass rd1=%h rd2=%h required 12345678/deadbeef", rd_data1, rd_data2);
      end
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
      #1;
      checks++;
      if (wr_accept !== 1'b1) begin
         errors++;
         $display("FAIL zero_accept got %b required 1", wr_accept);
      end
      tick();
      wr_en = 1'b0;
      checks++;
      if (rd_data1 !== 32'h0) begin
         errors++;
         $display("FAIL zero_bypass rd1=%h required 0", rd_data1);
      end
      tick();
      checks++;
      if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
         errors++;
         $display("FAIL zero_read rd1=%h rd2=%h required 0", rd_data1, rd_data2);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rd_addr1 = 5'($urandom_range(0, 31));
         rd_addr2 = (($urandom & 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
         wr_en    = 1'($urandom);
         wr_addr  = (($urandom & 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
         wr_data  = $urandom;
         clr_req  = ($urandom_range(0, 79) == 0);
         #1;
         checks++;
         if (wr_accept !== (wr_en && !m_busy) || busy !== m_busy) begin
            errors++;
            $display("FAIL rand_ctrl i=%0d acc=%b busy=%b required %b/%b", i, wr_accept, busy,
                     wr_en && !m_busy, m_busy);
         end
         tick();
         checks++;
         if (rd_data1 !== exp1 || rd_data2 !== exp2) begin
            errors++;
            $display("FAIL rand_read i=%0d rd1=%h rd2=%h required %h/%h", i, rd_data1, rd_data2,
                     exp1, exp2);
         end
`ifdef REGFILE_PARITY_EN
         checks++;
         if (rd_perr1 !== 1'b0 || rd_perr2 !== 1'b0) begin
            errors++;
            $display("FAIL rand_perr i=%0d perr=%b%b required 00", i, rd_perr1, rd_perr2);
         end
`endif
      end
      wr_en = 1'b0; clr_req = 1'b0;
      for (int i = 0; i < 40 && m_busy; i++) tick();
   endtask

   task automatic test_clear_hold();
      int n;
      for (int a = 1; a < 32; a++) begin
         wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
         tick();
      end
      wr_en = 1'b0; clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (wr_accept) break;
         n++;
         clr_req = (i == 5);
         tick();
         clr_req = 1'b0;
      end
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL clear_hold_stall got %0d cycles required 32", n);
      end
      tick();
      wr_en = 1'b0;
      for (int a = 0; a < 32; a++) begin
         rd_addr1 = 5'(a);
         rd_addr2 = 5'd3;
         tick();
         checks++;
         if (rd_data1 !== exp1 || rd_data1 !== ((a == 3) ? 32'hAA : 32'h0) ||
             rd_data2 !== 32'hAA) begin
            errors++;
            $display("FAIL clear_hold_read a=%0d rd1=%h rd2=%h required %h/000000aa", a,
                     rd_data1, rd_data2, exp1);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5A5A5A5A;
      tick();
      wr_en = 1'b0; rd_addr1 = 5'd5;
      tick();
      checks++;
      if (rd_data1 !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL pre_reset_read rd1=%h required 5a5a5a5a", rd_data1);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_data1 !== 32'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL async_reset rd1=%h busy=%b required 0/1", rd_data1, busy);
      end
      #2 rst_n = 1'b1;
      model_reset();
      count_busy(n);
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL idle_reset_busy_len got %0d required 32", n);
      end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_sweep_reset rd1=%h rd2=%h busy=%b required 0/0/1", rd_data1,
                  rd_data2, busy);
      end
      #2 rst_n = 1'b1;
      model_reset();
      count_busy(n);
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL mid_sweep_busy_len got %0d required 32", n);
      end
   endtask

`ifdef REGFILE_PARITY_EN
   task automatic test_parity();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0F0F0F0F;
      tick();
      wr_en = 1'b0;
      dut.mem_q[9] = dut.mem_q[9] ^ 32'h1;
      mem_m[9] = mem_m[9] ^ 32'h1;
      rd_addr1 = 5'd9; rd_addr2 = 5'd5;
      tick();
      checks++;
      if (rd_perr1 !== 1'b1 || rd_perr2 !== 1'b0 || rd_data1 !== 32'h0F0F0F0E) begin
         errors++;
         $display("FAIL parity_flip perr=%b%b rd1=%h required 10/0f0f0f0e", rd_perr1, rd_perr2,
                  rd_data1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_read_all();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_random();
      test_clear_hold();
      test_reset_mid_sweep();
`ifdef REGFILE_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
